button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning raw-input stable cycles before a change is accepted (legal range 1..2^24-1).
REQ-002 SHALL have port clk, input, 1, system clock.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port raw_btn, input, 5, asynchronous board buttons: bit4 U, bit3 D, bit2 L, bit1 R, bit0 C.
REQ-005 SHALL have port btnU, output, 1, debounced up level, held while pressed.
REQ-006 SHALL have port btnD, output, 1, debounced down level.
REQ-007 SHALL have port btnL, output, 1, debounced left level.
REQ-008 SHALL have port btnR, output, 1, debounced right level.
REQ-009 SHALL have port btnC_pulse, output, 1, one-cycle pulse on each accepted C press (start/serve).
REQ-010 SHALL have port any_held, output, 1, OR of the four debounced direction levels before opposition resolution.

Function
REQ-011 SHALL pass each raw_btn bit through a two-flop synchronizer; only the second-flop value s[i] is used downstream.
REQ-012 SHALL run five independent per-button FSMs with states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT and a counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-013 IDLE: s=1 -> PRESS_WAIT, counter cleared; else stay.
REQ-014 PRESS_WAIT: s=0 -> IDLE, counter cleared (bounce restarts qualification); s=1 and counter=DEBOUNCE_CYCLES-1 -> PRESSED; else counter+1.
REQ-015 PRESSED: s=0 -> RELEASE_WAIT, counter cleared; else stay.
REQ-016 RELEASE_WAIT: s=1 -> PRESSED, counter cleared; s=0 and counter=DEBOUNCE_CYCLES-1 -> IDLE; else counter+1.
REQ-017 Debounced level SHALL be 1 in PRESSED and RELEASE_WAIT, 0 otherwise; all outputs SHALL be registered.
REQ-018 Latency SHALL be exactly DEBOUNCE_CYCLES+3 clk edges from the first edge sampling a clean raw transition to the output change, identical for press and release.
REQ-019 btnC_pulse SHALL be high for exactly one cycle on the C FSM's PRESS_WAIT->PRESSED transition; holding C SHALL NOT repeat it.
REQ-020 DEBOUNCE_CYCLES=1 SHALL accept a change after one sampled cycle without counter overflow; the counter SHALL never exceed DEBOUNCE_CYCLES-1.
REQ-021 Opposing pairs (U/D, L/R) SHALL be resolved per REQ-026; non-opposing combinations (e.g. U with L) SHALL pass unchanged.

Reset
REQ-022 On rst assertion, all FSMs SHALL enter IDLE, counters and synchronizer flops SHALL clear, and btnU/btnD/btnL/btnR/btnC_pulse/any_held SHALL be 0 immediately.
REQ-023 A button held through rst deassertion SHALL be re-qualified from IDLE and assert after DEBOUNCE_CYCLES+3 cycles.
REQ-024 rst mid-PRESS_WAIT SHALL discard partial counts; no pulse SHALL be emitted for that press.

Configuration
REQ-025 Macro BTN_OPPOSE_CANCEL_EN SHALL select opposing-pair policy.
REQ-026 With BTN_OPPOSE_CANCEL_EN defined, both debounced U and D high SHALL drive btnU=btnD=0 (same for L/R); without it, U SHALL win over D and L over R (btnU=1,btnD=0; btnL=1,btnR=0).

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-027 raw U 0->1 held stable -> btnU rises exactly 7 edges later, any_held=1 same cycle; release -> btnU falls 7 edges after release.
REQ-028 raw U pulses high 3 cycles, low 1, high steady -> btnU rises 7 edges after the final rising edge; no glitch earlier.
REQ-029 raw C held 50 cycles -> btnC_pulse high exactly one cycle, 7 edges after press; second press after release+10 cycles -> second single pulse.
REQ-030 U and D both held stable -> with BTN_OPPOSE_CANCEL_EN btnU=btnD=0, any_held=1; without macro btnU=1, btnD=0.
REQ-031 rst asserted asynchronously while btnR=1 -> btnR=0 before next clk edge; R still held at rst release -> btnR=1 after 7 edges.
REQ-032 DEBOUNCE_CYCLES=1 build, raw L toggled every 2 cycles -> btnL follows with 4-edge latency, counter never exceeds 0.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner
//   Conditions the five raw board buttons (U, D, L, R, C): each bit is
//   synchronised, then debounced by its own four-state FSM. U/D/L/R come out
//   as held levels, C comes out as a single-cycle pulse per accepted press.
//   Every output is registered and changes DEBOUNCE_CYCLES+3 edges after the
//   first edge that samples a clean raw transition.
//
//   Build option: define BTN_OPPOSE_CANCEL_EN to make an opposing pair
//   (U/D or L/R) held together cancel to 0. Without it, U beats D and L
//   beats R.
module button_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000  // legal 1 .. 2^24-1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] raw_btn,
   output logic       btnU,
   output logic       btnD,
   output logic       btnL,
   output logic       btnR,
   output logic       btnC_pulse,
   output logic       any_held
);

   localparam int NUM_BTN = 5;
   localparam int BTN_U   = 4;
   localparam int BTN_D   = 3;
   localparam int BTN_L   = 2;
   localparam int BTN_R   = 1;
   localparam int BTN_C   = 0;

   localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   // Last count value before a change is accepted; the counter never passes it.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } state_t;

   logic [NUM_BTN-1:0] sync1_q;
   logic [NUM_BTN-1:0] sync2_q;

   state_t             state_q [NUM_BTN];
   state_t             state_d [NUM_BTN];
   logic [CNT_W-1:0]   cnt_q   [NUM_BTN];
   logic [CNT_W-1:0]   cnt_d   [NUM_BTN];

   logic [NUM_BTN-1:0] lvl_d;
   logic               press_d;
   logic               btn_u_d;
   logic               btn_d_d;
   logic               btn_l_d;
   logic               btn_r_d;
   logic               any_d;

   // Per-button debounce next-state: qualify a level change over DEBOUNCE_CYCLES samples.
   always_comb begin
      for (int i = 0; i < NUM_BTN; i++) begin
         // NOTE: defaults first on every path, so the combinational block infers no latch.
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            IDLE: begin
               if (sync2_q[i]) begin
                  state_d[i] = PRESS_WAIT;
                  cnt_d[i]   = '0;
               end
            end
            PRESS_WAIT: begin
               if (!sync2_q[i]) begin
                  // A bounce throws away the partial qualification.
                  state_d[i] = IDLE;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == CNT_LAST) begin
                  state_d[i] = PRESSED;
                  cnt_d[i]   = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            PRESSED: begin
               if (!sync2_q[i]) begin
                  state_d[i] = RELEASE_WAIT;
                  cnt_d[i]   = '0;
               end
            end
            RELEASE_WAIT: begin
               if (sync2_q[i]) begin
                  state_d[i] = PRESSED;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == CNT_LAST) begin
                  state_d[i] = IDLE;
                  cnt_d[i]   = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            default: begin
               state_d[i] = IDLE;
               cnt_d[i]   = '0;
            end
         endcase
         // The debounced level stays high while a release is still being qualified.
         lvl_d[i] = (state_d[i] == PRESSED) || (state_d[i] == RELEASE_WAIT);
      end
      press_d = (state_q[BTN_C] == PRESS_WAIT) && (state_d[BTN_C] == PRESSED);
   end

   // Opposing-pair resolution on the next debounced levels, ahead of the output registers.
   always_comb begin
`ifdef BTN_OPPOSE_CANCEL_EN
      btn_u_d = lvl_d[BTN_U] & ~lvl_d[BTN_D];
      btn_d_d = lvl_d[BTN_D] & ~lvl_d[BTN_U];
      btn_l_d = lvl_d[BTN_L] & ~lvl_d[BTN_R];
      btn_r_d = lvl_d[BTN_R] & ~lvl_d[BTN_L];
`else
      btn_u_d = lvl_d[BTN_U];
      btn_d_d = lvl_d[BTN_D] & ~lvl_d[BTN_U];
      btn_l_d = lvl_d[BTN_L];
      btn_r_d = lvl_d[BTN_R] & ~lvl_d[BTN_L];
`endif
      any_d = lvl_d[BTN_U] | lvl_d[BTN_D] | lvl_d[BTN_L] | lvl_d[BTN_R];
   end

   // Synchronisers, FSM state/counters and registered outputs; async reset clears all.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         for (int i = 0; i < NUM_BTN; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
         end
         btnU       <= 1'b0;
         btnD       <= 1'b0;
         btnL       <= 1'b0;
         btnR       <= 1'b0;
         btnC_pulse <= 1'b0;
         any_held   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments, so every flop samples the pre-edge values.
         sync1_q    <= raw_btn;
         sync2_q    <= sync1_q;
         for (int i = 0; i < NUM_BTN; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         btnU       <= btn_u_d;
         btnD       <= btn_d_d;
         btnL       <= btn_l_d;
         btnR       <= btn_r_d;
         btnC_pulse <= press_d;
         any_held   <= any_d;
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner. Two instances share stimulus: one with
// DEBOUNCE_CYCLES=4, one with DEBOUNCE_CYCLES=1. A reference model advances
// on each clock edge and queues the expected outputs of both; a monitor pops
// and compares on the falling edge. Expected behaviour of the model: a button
// output flips once the value seen after the two-stage synchroniser has
// differed from the current level for DEBOUNCE_CYCLES+1 consecutive edges.
module tb_button_conditioner;

   localparam int N_A = 4;
   localparam int N_B = 1;

   logic       clk     = 1'b0;
   logic       rst     = 1'b0;
   logic [4:0] raw_btn = 5'd0;

   logic a_u, a_d, a_l, a_r, a_c, a_any;
   logic b_u, b_d, b_l, b_r, b_c, b_any;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   button_conditioner #(.DEBOUNCE_CYCLES(N_A)) dut_a (
      .clk(clk), .rst(rst), .raw_btn(raw_btn),
      .btnU(a_u), .btnD(a_d), .btnL(a_l), .btnR(a_r),
      .btnC_pulse(a_c), .any_held(a_any)
   );

   button_conditioner #(.DEBOUNCE_CYCLES(N_B)) dut_b (
      .clk(clk), .rst(rst), .raw_btn(raw_btn),
      .btnU(b_u), .btnD(b_d), .btnL(b_l), .btnR(b_r),
      .btnC_pulse(b_c), .any_held(b_any)
   );

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   // {U, D, L, R, C pulse, any_held}
   function automatic logic [5:0] resolve(input logic [4:0] lv, input logic pulse);
      logic u, d, l, r;
`ifdef BTN_OPPOSE_CANCEL_EN
      u = lv[4] & ~lv[3];
      d = lv[3] & ~lv[4];
      l = lv[2] & ~lv[1];
      r = lv[1] & ~lv[2];
`else
      u = lv[4];
      d = lv[3] & ~lv[4];
      l = lv[2];
      r = lv[1] & ~lv[2];
`endif
      return {u, d, l, r, pulse, |lv[4:1]};
   endfunction

   // ---------------- reference model ----------------
   logic [4:0]  m_hist0, m_hist1, m_seen;
   logic [4:0]  m_lvl [2];
   int          m_run [2][5];
   int          m_n   [2] = '{N_A, N_B};
   logic [5:0]  m_out [2];
   logic        m_pulse;
   logic [11:0] exp_q [$];

   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            m_hist0 = '0;
            m_hist1 = '0;
            for (int k = 0; k < 2; k++) begin
               m_lvl[k] = '0;
               m_out[k] = '0;
               for (int b = 0; b < 5; b++) m_run[k][b] = 0;
            end
         end else begin
            // Value the debouncers see this edge: raw as sampled two edges ago.
            m_seen  = m_hist1;
            m_hist1 = m_hist0;
            m_hist0 = raw_btn;
            for (int k = 0; k < 2; k++) begin
               m_pulse = 1'b0;
               for (int b = 0; b < 5; b++) begin
                  if (m_seen[b] != m_lvl[k][b]) begin
                     m_run[k][b]++;
                     if (m_run[k][b] == m_n[k] + 1) begin
                        m_lvl[k][b] = m_seen[b];
                        m_run[k][b] = 0;
                        if (b == 0 && m_seen[b]) m_pulse = 1'b1;
                     end
                  end else begin
                     m_run[k][b] = 0;
                  end
               end
               m_out[k] = resolve(m_lvl[k], m_pulse);
            end
         end
         exp_q.push_back({m_out[0], m_out[1]});
      end
   end

   // ---------------- monitor ----------------
   logic [11:0] mon_exp;

   initial begin
      forever begin
         @(negedge clk);
         check("sb_depth", exp_q.size(), 1);
         if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            check("outs_n4", {a_u, a_d, a_l, a_r, a_c, a_any}, mon_exp[11:6]);
            check("outs_n1", {b_u, b_d, b_l, b_r, b_c, b_any}, mon_exp[5:0]);
            exp_q.delete();
         end
         for (int i = 0; i < 5; i++) begin
            check("cnt_n1_bound", int'(dut_b.cnt_q[i]), 0);
            check("cnt_n4_bound", int'(dut_a.cnt_q[i] <= 3), 1);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic hold(input logic [4:0] v, input int n);
      @(negedge clk);
      raw_btn = v;
      repeat (n - 1) @(negedge clk);
   endtask

   initial begin
      #1 rst = 1'b1;
      #1;
      check("reset_outs_n4", {a_u, a_d, a_l, a_r, a_c, a_any}, 0);
      check("reset_outs_n1", {b_u, b_d, b_l, b_r, b_c, b_any}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // U clean press and release
      hold(5'b10000, 20);
      hold(5'b00000, 20);
      // U bouncing: 3 high, 1 low, then steady
      hold(5'b10000, 3);
      hold(5'b00000, 1);
      hold(5'b10000, 20);
      hold(5'b00000, 20);
      // C held 50 cycles, released, then a second press
      hold(5'b00001, 50);
      hold(5'b00000, 20);
      hold(5'b00001, 20);
      hold(5'b00000, 20);
      // Opposing and non-opposing combinations
      hold(5'b11000, 20);
      hold(5'b00000, 20);
      hold(5'b00110, 20);
      hold(5'b00000, 20);
      hold(5'b10100, 20);
      hold(5'b00000, 20);
      // L toggling every 2 cycles: only the DEBOUNCE_CYCLES=1 instance follows
      for (int i = 0; i < 12; i++) hold((i % 2 == 0) ? 5'b00100 : 5'b00000, 2);
      hold(5'b00000, 20);

      // R held, asynchronous reset mid-cycle, R still held afterwards
      hold(5'b00010, 20);
      @(negedge clk);
      check("pre_rst_btnR", a_r, 1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_btnR_n4", a_r, 0);
      check("async_rst_btnR_n1", b_r, 0);
      check("async_rst_any", a_any, 0);
      @(negedge clk);
      rst = 1'b0;
      hold(5'b00010, 20);
      hold(5'b00000, 20);

      // Reset in the middle of a C qualification: no pulse may follow
      hold(5'b00001, 4);
      @(negedge clk);
      rst     = 1'b1;
      raw_btn = 5'b00000;
      @(negedge clk);
      rst = 1'b0;
      hold(5'b00000, 20);

      // Randomised segments
      for (int i = 0; i < 250; i++) begin
         hold(5'($urandom_range(0, 31)), int'($urandom_range(1, 9)));
      end
      hold(5'b00000, 20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
